// File: rtl/config_pkg.sv
// Shared constants, state encoding and header validation for the packet controller.
//   OP_ECHO / OP_ADD / OP_MUL : opcode byte values
//   ctrl_state_e              : controller state encoding
//   HDR_BYTES                 : header length in bytes
//   hdr_ok()                  : legality check applied when len_hi arrives
package config_pkg;

  localparam int unsigned HDR_BYTES = 4;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hAD;
  localparam logic [7:0] OP_MUL  = 8'hAC;

  typedef enum logic [2:0] {
    HDR0, HDR1, HDR2, HDR3, ECHO, ACCUM, SEND, DRAIN
  } ctrl_state_e;

  // Header legality: known opcode, len within [HDR_BYTES, max_len], and
  // arithmetic packets carry a non-empty whole number of 32-bit words.
  function automatic logic hdr_ok(input logic [7:0]  op,
                                  input logic [15:0] len,
                                  input logic [15:0] max_len);
    logic [15:0] pay;
    pay    = len - 16'(HDR_BYTES);
    hdr_ok = 1'b0;
    if ((len >= 16'(HDR_BYTES)) && (len <= max_len)) begin
      case (op)
        OP_ECHO:        hdr_ok = 1'b1;
        OP_ADD, OP_MUL: hdr_ok = (pay != 16'd0) && (pay[1:0] == 2'd0);
        default:        hdr_ok = 1'b0;
      endcase
    end
  endfunction

endpackage

// File: rtl/alu_word_op.sv
// Combinational word operation folded into the accumulator.
//   opcode : OP_MUL selects low-32 multiply, anything else selects add
//   acc    : current accumulator
//   word   : incoming 32-bit operand
//   result : op(acc, word), wrapped to 32 bits
module alu_word_op
  import config_pkg::*;
(
  input  logic [7:0]  opcode,
  input  logic [31:0] acc,
  input  logic [31:0] word,
  output logic [31:0] result
);

  always_comb begin
    result = acc + word;
    if (opcode == OP_MUL) begin
      result = acc * word;
    end
  end

endmodule

// File: rtl/alu_packet_ctrl.sv
// Byte-stream packet controller: parses framed commands from RX, echoes the
// payload or folds 32-bit operands through add/multiply, and streams the
// result on TX. Malformed packets are drained and flagged on err_o.
//   clk, rst              : clock, synchronous active-high reset
//   rx_data_i/valid/ready : inbound byte stream (valid & ready transfers)
//   tx_data_o/valid/ready : outbound byte stream, registered and held until taken
//   busy_o                : packet in progress (state is not HDR0)
//   err_o                 : one-cycle pulse when a packet is rejected
module alu_packet_ctrl
  import config_pkg::*;
#(
  parameter logic [15:0] MAX_LEN_P = 16'd1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       busy_o,
  output logic       err_o
);

  ctrl_state_e state_q;
  logic [7:0]  opcode_q;
  logic [7:0]  len_lo_q;
  logic [15:0] rem_q;
  logic [31:0] acc_q;
  logic [23:0] shreg_q;
  logic [1:0]  byte_idx_q;
  logic [1:0]  send_cnt_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic        err_q;

  logic        rx_ready_c;
  logic        rx_acc_c;
  logic        tx_hs_c;
  logic [15:0] len_c;
  logic [15:0] pay_c;
  logic [31:0] word_c;
  logic [31:0] alu_res_c;

  // Ready depends on state; in ECHO it also tracks TX register occupancy.
  always_comb begin
    rx_ready_c = 1'b0;
    case (state_q)
      HDR0, HDR1, HDR2, HDR3, ACCUM, DRAIN: rx_ready_c = 1'b1;
      ECHO:    rx_ready_c = (rem_q != 16'd0) && (!tx_valid_q || tx_ready_i);
      default: rx_ready_c = 1'b0;
    endcase
  end

  assign rx_acc_c = rx_valid_i & rx_ready_c;
  assign tx_hs_c  = tx_valid_q & tx_ready_i;
  assign len_c    = {rx_data_i, len_lo_q};
  assign pay_c    = len_c - 16'(HDR_BYTES);
  assign word_c   = {rx_data_i, shreg_q};

  alu_word_op u_word_op (
    .opcode (opcode_q),
    .acc    (acc_q),
    .word   (word_c),
    .result (alu_res_c)
  );

  // Controller state machine with registered TX and error outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HDR0;
      opcode_q   <= 8'd0;
      len_lo_q   <= 8'd0;
      rem_q      <= 16'd0;
      acc_q      <= 32'd0;
      shreg_q    <= 24'd0;
      byte_idx_q <= 2'd0;
      send_cnt_q <= 2'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (tx_hs_c) begin
        tx_valid_q <= 1'b0;
      end
      case (state_q)
        HDR0: if (rx_acc_c) begin
          opcode_q <= rx_data_i;
          state_q  <= HDR1;
        end
        HDR1: if (rx_acc_c) begin
          state_q <= HDR2;
        end
        HDR2: if (rx_acc_c) begin
          len_lo_q <= rx_data_i;
          state_q  <= HDR3;
        end
        HDR3: if (rx_acc_c) begin
          byte_idx_q <= 2'd0;
          shreg_q    <= 24'd0;
          if (!hdr_ok(opcode_q, len_c, MAX_LEN_P)) begin
            err_q <= 1'b1;
            // len <= HDR_BYTES leaves nothing to drain
            if (len_c <= 16'(HDR_BYTES)) begin
              rem_q   <= 16'd0;
              state_q <= HDR0;
            end else begin
              rem_q   <= pay_c;
              state_q <= DRAIN;
            end
          end else if (opcode_q == OP_ECHO) begin
            rem_q   <= pay_c;
            state_q <= (pay_c == 16'd0) ? HDR0 : ECHO;
          end else begin
            rem_q   <= pay_c;
            acc_q   <= (opcode_q == OP_MUL) ? 32'd1 : 32'd0;
            state_q <= ACCUM;
          end
        end
        ECHO: begin
          if (rx_acc_c) begin
            tx_data_q  <= rx_data_i;
            tx_valid_q <= 1'b1;
            rem_q      <= rem_q - 16'd1;
          end else if ((rem_q == 16'd0) && (tx_hs_c || !tx_valid_q)) begin
            state_q <= HDR0;
          end
        end
        ACCUM: if (rx_acc_c) begin
          rem_q <= rem_q - 16'd1;
          if (byte_idx_q == 2'd3) begin
            acc_q      <= alu_res_c;
            byte_idx_q <= 2'd0;
            // Final word: result byte 0 goes straight into the TX register
            if (rem_q == 16'd1) begin
              state_q    <= SEND;
              send_cnt_q <= 2'd0;
              tx_data_q  <= alu_res_c[7:0];
              tx_valid_q <= 1'b1;
            end
          end else begin
            shreg_q    <= {rx_data_i, shreg_q[23:8]};
            byte_idx_q <= byte_idx_q + 2'd1;
          end
        end
        SEND: if (tx_hs_c) begin
          if (send_cnt_q == 2'd3) begin
            state_q <= HDR0;
          end else begin
            send_cnt_q <= send_cnt_q + 2'd1;
            tx_valid_q <= 1'b1;
            case (send_cnt_q)
              2'd0:    tx_data_q <= acc_q[15:8];
              2'd1:    tx_data_q <= acc_q[23:16];
              default: tx_data_q <= acc_q[31:24];
            endcase
          end
        end
        DRAIN: if (rx_acc_c) begin
          rem_q <= rem_q - 16'd1;
          if (rem_q == 16'd1) begin
            state_q <= HDR0;
          end
        end
        default: state_q <= HDR0;
      endcase
    end
  end

  assign rx_ready_o = rx_ready_c;
  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign busy_o     = (state_q != HDR0);
  assign err_o      = err_q;

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Self-checking bench for alu_packet_ctrl: table of whole packets with
// hand-computed TX bytes and error expectations, plus directed sequences
// for latency, back-pressure, length boundaries and mid-packet reset.
module tb_alu_packet_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_ready_set;
  logic       toggle;
  logic       phase = 1'b0;
  logic       busy;
  logic       err;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int viol_cnt = 0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;
  always @(negedge clk) phase = ~phase;
  assign tx_ready = toggle ? phase : tx_ready_set;

  alu_packet_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data_i  (rx_data),
    .rx_valid_i (rx_valid),
    .rx_ready_o (rx_ready),
    .tx_data_o  (tx_data),
    .tx_valid_o (tx_valid),
    .tx_ready_i (tx_ready),
    .busy_o     (busy),
    .err_o      (err)
  );

  // Observe settled signals mid-cycle; they are what the next edge will see.
  always @(negedge clk) begin
    #1;
    if (!rst && tx_valid && tx_ready) txq.push_back(tx_data);
    if (!rst && err) err_cnt++;
    if (!rst && rx_valid && rx_ready && tx_valid && !tx_ready) viol_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    #1;
    while (!rx_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!rx_ready) check("rx_accept_timeout", 32'(rx_ready), 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [15:0] len);
    send_byte(op);
    send_byte(8'h00);
    send_byte(len[7:0]);
    send_byte(len[15:8]);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    #1;
    while ((busy || tx_valid) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (busy || tx_valid) check("idle_timeout", {30'd0, busy, tx_valid}, 32'd0);
    @(negedge clk);
  endtask

  // Packet vectors; byte strings are written left to right in wire order.
  typedef struct packed {
    logic [7:0]  op;
    logic [15:0] len;
    logic [4:0]  npay;
    logic [95:0] pay;
    logic [4:0]  nexp;
    logic [95:0] exp;
    logic        exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] op, input logic [15:0] len,
                              input int npay, input logic [95:0] pay,
                              input int nexp, input logic [95:0] exp,
                              input logic exp_err);
    vec_t v;
    v.op = op; v.len = len; v.npay = 5'(npay); v.pay = pay;
    v.nexp = 5'(nexp); v.exp = exp; v.exp_err = exp_err;
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    vecs[0]  = mk(8'hEC, 16'd6,  2,  96'h6869,                      2, 96'h6869,     1'b0);
    vecs[1]  = mk(8'hAD, 16'd12, 8,  96'h05000000_07000000,         4, 96'h0C000000, 1'b0);
    vecs[2]  = mk(8'hAC, 16'd12, 8,  96'hFFFFFFFF_02000000,         4, 96'hFEFFFFFF, 1'b0);
    vecs[3]  = mk(8'h77, 16'd8,  4,  96'h01020304,                  0, 96'h0,        1'b1);
    vecs[4]  = mk(8'hAD, 16'd8,  4,  96'h01000000,                  4, 96'h01000000, 1'b0);
    vecs[5]  = mk(8'hAD, 16'd16, 12, 96'h04030201_40302010_FFFFFFFF, 4, 96'h43332211, 1'b0);
    vecs[6]  = mk(8'hAD, 16'd6,  2,  96'hAABB,                      0, 96'h0,        1'b1);
    vecs[7]  = mk(8'hEC, 16'd4,  0,  96'h0,                         0, 96'h0,        1'b0);
    vecs[8]  = mk(8'hEC, 16'd2,  0,  96'h0,                         0, 96'h0,        1'b1);
    vecs[9]  = mk(8'hAC, 16'd4,  0,  96'h0,                         0, 96'h0,        1'b1);
    vecs[10] = mk(8'hAC, 16'd12, 8,  96'h03000000_05000000,         4, 96'h0F000000, 1'b0);

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready_set = 1'b1; toggle = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_rx_ready", 32'(rx_ready), 32'd1);
    check("reset_tx_valid", 32'(tx_valid), 32'd0);
    check("reset_tx_data",  32'(tx_data),  32'd0);
    check("reset_busy",     32'(busy),     32'd0);
    check("reset_err",      32'(err),      32'd0);
    @(negedge clk);

    // Table-driven packets with TX held ready.
    for (int v = 0; v < NV; v++) begin
      txq.delete();
      err_cnt = 0;
      send_hdr(vecs[v].op, vecs[v].len);
      for (int i = 0; i < int'(vecs[v].npay); i++)
        send_byte(vecs[v].pay[8*(int'(vecs[v].npay)-1-i) +: 8]);
      wait_idle(100);
      check($sformatf("vec%0d_tx_count", v), 32'(txq.size()), 32'(vecs[v].nexp));
      for (int i = 0; i < int'(vecs[v].nexp) && i < txq.size(); i++)
        check($sformatf("vec%0d_tx_byte%0d", v, i), 32'(txq[i]),
              32'(vecs[v].exp[8*(int'(vecs[v].nexp)-1-i) +: 8]));
      check($sformatf("vec%0d_err_pulses", v), 32'(err_cnt), 32'(vecs[v].exp_err));
    end

    // ECHO latency: each byte is on TX in the cycle after its RX handshake.
    txq.delete();
    send_hdr(8'hEC, 16'd6);
    send_byte(8'h68);
    #1;
    check("echo_lat_valid0", 32'(tx_valid), 32'd1);
    check("echo_lat_data0",  32'(tx_data),  32'h68);
    send_byte(8'h69);
    #1;
    check("echo_lat_valid1", 32'(tx_valid), 32'd1);
    check("echo_lat_data1",  32'(tx_data),  32'h69);
    @(negedge clk);
    #1;
    check("echo_done_busy",  32'(busy),     32'd0);
    check("echo_done_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);

    // SEND holds result and refuses RX while TX is stalled.
    txq.delete();
    tx_ready_set = 1'b0;
    send_hdr(8'hAD, 16'd12);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h07); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    rx_valid = 1'b1; rx_data = 8'h55;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("send_rx_ready_c%0d", c), 32'(rx_ready), 32'd0);
      check($sformatf("send_hold_c%0d", c), {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h0C});
      @(negedge clk);
    end
    rx_valid = 1'b0;
    tx_ready_set = 1'b1;
    wait_idle(50);
    check("send_stall_count", 32'(txq.size()), 32'd4);
    if (txq.size() == 4)
      check("send_stall_word", {txq[3], txq[2], txq[1], txq[0]}, 32'h0000000C);

    // ECHO under toggling TX ready: order preserved, no overrun.
    txq.delete();
    viol_cnt = 0;
    toggle = 1'b1;
    send_hdr(8'hEC, 16'd10);
    for (int i = 0; i < 6; i++) send_byte(8'(8'h11 * (i + 1)));
    wait_idle(100);
    toggle = 1'b0;
    check("toggle_count", 32'(txq.size()), 32'd6);
    for (int i = 0; i < 6 && i < txq.size(); i++)
      check($sformatf("toggle_byte%0d", i), 32'(txq[i]), 32'(8'(8'h11 * (i + 1))));
    check("toggle_no_overrun", 32'(viol_cnt), 32'd0);

    // Length just over the limit: rejected and fully drained.
    txq.delete();
    err_cnt = 0;
    send_hdr(8'hEC, 16'd1025);
    for (int i = 0; i < 1021; i++) send_byte(8'(i));
    wait_idle(20);
    check("overmax_err", 32'(err_cnt), 32'd1);
    check("overmax_no_tx", 32'(txq.size()), 32'd0);

    // Length exactly at the limit: accepted and echoed.
    txq.delete();
    err_cnt = 0;
    send_hdr(8'hEC, 16'd1024);
    for (int i = 0; i < 1020; i++) send_byte(8'(i * 7));
    wait_idle(20);
    check("maxlen_err", 32'(err_cnt), 32'd0);
    check("maxlen_count", 32'(txq.size()), 32'd1020);
    begin
      int bad = 0;
      for (int i = 0; i < 1020 && i < txq.size(); i++)
        if (txq[i] !== 8'(i * 7)) bad++;
      check("maxlen_payload_errors", 32'(bad), 32'd0);
    end

    // Reset in the middle of ACCUM, then a clean packet.
    txq.delete();
    send_hdr(8'hAD, 16'd12);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h09); send_byte(8'h00);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_tx_valid", 32'(tx_valid), 32'd0);
    check("midrst_busy",     32'(busy),     32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_hdr(8'hAD, 16'd8);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_idle(50);
    check("midrst_count", 32'(txq.size()), 32'd4);
    if (txq.size() == 4)
      check("midrst_result", {txq[3], txq[2], txq[1], txq[0]}, 32'h00000002);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
